// File: rtl/data_sram_like_bridge.sv
// data_sram_like_bridge: turns each single-cycle CPU data access into one sram-like
// req/addr_ok/data_ok transaction, stalling the CPU until the response arrives.
module data_sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cpu_hold,
    input  logic              cpu_flush,
    output logic              mem_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
    state_t state, state_nxt;
    logic capture;
    logic [1:0] size_nxt;

    always_comb begin
        state_nxt = state;
        capture = 1'b0;
        case (state)
            IDLE: state_nxt = (cpu_en && !cpu_flush) ? REQ : IDLE;
            REQ: begin
                if (data_addr_ok && data_data_ok) begin
                    state_nxt = cpu_flush ? IDLE : DONE;
                    capture = !cpu_flush;
                end else if (data_addr_ok) begin
                    state_nxt = cpu_flush ? DRAIN : WAIT;
                end else if (cpu_flush) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                // a flushed access still has to see its response before the bus is free
                if (cpu_flush) begin
                    state_nxt = data_data_ok ? IDLE : DRAIN;
                end else if (data_data_ok) begin
                    state_nxt = DONE;
                    capture = 1'b1;
                end
            end
            DONE: state_nxt = cpu_hold ? DONE : IDLE;
            DRAIN: state_nxt = data_data_ok ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    assign size_nxt = (cpu_wen == 4'b1111 || cpu_wen == 4'b0000) ? 2'd2 :
                      (cpu_wen == 4'b0011 || cpu_wen == 4'b1100) ? 2'd1 : 2'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= '0;
            data_wdata <= '0;
            cpu_rdata  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == REQ) begin
                data_wr    <= |cpu_wen;
                data_size  <= size_nxt;
                data_addr  <= (|cpu_wen) ? cpu_addr : {cpu_addr[ADDR_W-1:2], 2'b00};
                data_wdata <= cpu_wdata;
            end
            if (capture && !data_wr) cpu_rdata <= data_rdata;
        end
    end

    assign data_req  = state == REQ;
    assign mem_stall = resetn & cpu_en & ~cpu_flush & (state == IDLE || state == REQ || state == WAIT);
endmodule

// File: tb/tb_data_sram_like_bridge.sv
// tb_data_sram_like_bridge: scenario tasks plus randomized accesses checked against a
// transaction-level model of the bridge (expected request, stall length, held read data).
module tb_data_sram_like_bridge;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic cpu_en = 1'b0, cpu_hold = 1'b0, cpu_flush = 1'b0;
    logic [3:0] cpu_wen = 4'h0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, data_rdata = '0;
    logic data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0] cpu_rdata, data_addr, data_wdata;
    logic mem_stall, data_req, data_wr;
    logic [1:0] data_size;
    int errors = 0, checks = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    data_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold), .cpu_flush(cpu_flush), .mem_stall(mem_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    function automatic logic [1:0] exp_size(input logic [3:0] wen);
        int n = $countones(wen);
        return (n == 4 || n == 0) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
    endfunction

    // One full CPU access; caller is at a negedge with the bridge in IDLE.
    // a_lat: REQ cycles before addr_ok; d_lat: cycles after accept until data_ok.
    task automatic run_access(input logic [3:0] wen, input logic [31:0] addr, wdata, rd,
                              input int a_lat, d_lat, hold);
        logic wr;
        logic [31:0] eaddr;
        int nreq, since, nstall;
        bit acc, got;
        wr = |wen;
        eaddr = wr ? addr : {addr[31:2], 2'b00};
        nreq = 0; since = 0; nstall = 0; acc = 0; got = 0;
        cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
        cpu_hold = 1'b0; cpu_flush = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
            #1;
            checks++;
            if (mem_stall !== 1'b1) begin
                errors++; $display("FAIL stall_active cycle %0d got %b exp 1", c, mem_stall);
            end
            nstall++;
            if (data_req) begin
                checks++;
                if ({acc, data_wr, data_size, data_addr} !== {1'b0, wr, exp_size(wen), eaddr} ||
                    (wr && data_wdata !== wdata)) begin
                    errors++;
                    $display("FAIL req_attr got acc=%b wr=%b size=%0d addr=%h wdata=%h exp wr=%b size=%0d addr=%h wdata=%h",
                             acc, data_wr, data_size, data_addr, data_wdata, wr, exp_size(wen), eaddr, wdata);
                end
                if (nreq == a_lat) begin
                    data_addr_ok = 1'b1; acc = 1;
                    if (d_lat == 0) begin data_data_ok = 1'b1; data_rdata = rd; got = 1; end
                end
                nreq++;
            end else if (acc) begin
                since++;
                if (since == d_lat) begin data_data_ok = 1'b1; data_rdata = rd; got = 1; end
            end
            @(negedge clk);
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        if (!got) begin
            errors++; $display("FAIL access_timeout got no data_ok exp completion");
        end
        if (!wr) exp_rdata = rd;
        checks++;
        if (nstall != 2 + a_lat + d_lat) begin
            errors++; $display("FAIL stall_cycles got %0d exp %0d", nstall, 2 + a_lat + d_lat);
        end
        for (int h = 0; h <= hold; h++) begin
            cpu_hold = (h < hold);
            #1;
            checks++;
            if ({mem_stall, data_req, cpu_rdata} !== {2'b00, exp_rdata}) begin
                errors++;
                $display("FAIL done_state got stall=%b req=%b rdata=%h exp stall=0 req=0 rdata=%h",
                         mem_stall, data_req, cpu_rdata, exp_rdata);
            end
            @(negedge clk);
        end
        cpu_hold = 1'b0; cpu_en = 1'b0;
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({data_req, mem_stall, data_wr, data_size, data_addr, data_wdata, cpu_rdata} !== '0) begin
            errors++;
            $display("FAIL %s got req=%b stall=%b wr=%b size=%0d addr=%h wdata=%h rdata=%h exp all 0",
                     name, data_req, mem_stall, data_wr, data_size, data_addr, data_wdata, cpu_rdata);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; cpu_en = 1'b1;
        @(negedge clk); @(negedge clk);
        #1 check_zero_outputs("reset_outputs");
        @(negedge clk);
        resetn = 1'b1; cpu_en = 1'b0;
        exp_rdata = '0;
    endtask

    task automatic test_read_wait;
        run_access(4'b0000, 32'h1FC0_0006, 32'h0, 32'hDEAD_BEEF, 0, 3, 0);
    endtask

    task automatic test_store_fast;
        run_access(4'b1100, 32'h8000_0012, 32'hABCD_0000, 32'h5555_5555, 0, 0, 0);
    endtask

    task automatic test_flush_req;
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_2000;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (data_req !== 1'b1) begin
                errors++; $display("FAIL flush_req_pending cycle %0d got %b exp 1", i, data_req);
            end
            if (i == 3) begin
                cpu_flush = 1'b1;
                #1;
                checks++;
                if (mem_stall !== 1'b0) begin
                    errors++; $display("FAIL flush_req_stall got %b exp 0", mem_stall);
                end
            end
            @(negedge clk);
        end
        cpu_flush = 1'b0; cpu_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({data_req, mem_stall} !== 2'b00) begin
                errors++; $display("FAIL flush_req_idle got req=%b stall=%b exp 0 0", data_req, mem_stall);
            end
            @(negedge clk);
        end
        run_access(4'b0001, 32'h0000_2003, 32'h0000_00AA, 32'h0, 1, 1, 0);
    endtask

    task automatic test_flush_wait;
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0100;
        @(negedge clk);
        #1 data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0; cpu_flush = 1'b1;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++; $display("FAIL flush_wait_stall got %b exp 0", mem_stall);
        end
        @(negedge clk);
        cpu_flush = 1'b0; cpu_en = 1'b1; cpu_addr = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({data_req, mem_stall} !== 2'b00) begin
                errors++; $display("FAIL drain_quiet cycle %0d got req=%b stall=%b exp 0 0", i, data_req, mem_stall);
            end
            @(negedge clk);
        end
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        checks++;
        if ({data_req, mem_stall, cpu_rdata} !== {2'b01, exp_rdata}) begin
            errors++;
            $display("FAIL drain_exit got req=%b stall=%b rdata=%h exp req=0 stall=1 rdata=%h",
                     data_req, mem_stall, cpu_rdata, exp_rdata);
        end
        run_access(4'b0000, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 0, 2, 0);
    endtask

    task automatic test_done_hold;
        run_access(4'b0000, 32'h0000_0044, 32'h0, 32'h0BAD_C0DE, 2, 1, 3);
    endtask

    task automatic test_reset_in_wait;
        cpu_en = 1'b1; cpu_wen = 4'b1111; cpu_addr = 32'h0000_3008; cpu_wdata = 32'hFFFF_0001;
        @(negedge clk);
        #1 data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1 resetn = 1'b0;
        #1 check_zero_outputs("reset_in_wait");
        exp_rdata = '0;
        @(negedge clk);
        resetn = 1'b1; cpu_en = 1'b0;
        #1;
        checks++;
        if ({data_req, mem_stall} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle got req=%b stall=%b exp 0 0", data_req, mem_stall);
        end
        @(negedge clk);
        run_access(4'b0000, 32'h0000_300A, 32'h0, 32'h7777_8888, 0, 1, 0);
    endtask

    task automatic test_back_to_back;
        logic [3:0] wens [8] = '{4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        for (int i = 0; i < 24; i++)
            run_access(wens[$urandom_range(7)], $urandom, $urandom, $urandom,
                       $urandom_range(3), $urandom_range(3), $urandom_range(2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_read_wait();
        test_store_fast();
        test_flush_req();
        test_flush_wait();
        test_done_hold();
        test_reset_in_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
